// File: rtl/pipelined_rca.sv
// pipelined_rca: WIDTH-bit ripple adder/subtractor resolving SEG bits per stage,
// with carry, partial sums and unused operand bits registered between stages.
module pipelined_rca #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = WIDTH / SEG;
  // Operand chain is triangular: stage k sees only its WIDTH-k*SEG unresolved bits.
  localparam int OPW = STAGES * WIDTH - SEG * STAGES * (STAGES - 1) / 2;
  localparam int PSW = SEG * STAGES * (STAGES + 1) / 2;
  logic [OPW-1:0]  opa, opb;
  logic [PSW-1:0]  ps;
  logic [STAGES:0] cy, v;
  logic            adv;
  assign adv       = !v[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v[STAGES];
  assign c_out     = cy[STAGES];
  assign sum       = ps[PSW-1 -: WIDTH];
  assign v[0]      = in_valid;
  assign cy[0]     = op_sub ^ c_in;
  assign opa[WIDTH-1:0] = a;
  assign opb[WIDTH-1:0] = b ^ {WIDTH{op_sub}};
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int R  = WIDTH - k * SEG;
    localparam int OI = k * WIDTH - SEG * k * (k - 1) / 2;
    localparam int PO = SEG * k * (k + 1) / 2;
    logic [SEG:0]           seg_s;
    logic [(k+1)*SEG-1:0]   ps_d, ps_q;
    logic                   cy_d, cy_q, v_q;
    assign seg_s = {1'b0, opa[OI +: SEG]} + {1'b0, opb[OI +: SEG]} + {{SEG{1'b0}}, cy[k]};
    if (k == 0) begin : s0
      always_comb ps_d = seg_s[SEG-1:0];
    end else begin : sk
      always_comb ps_d = {seg_s[SEG-1:0], ps[PO-k*SEG +: k*SEG]};
    end
    always_comb cy_d = seg_s[SEG];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        cy_q <= 1'b0;
        ps_q <= '0;
      end else if (adv) begin
        v_q  <= v[k];
        cy_q <= cy_d;
        ps_q <= ps_d;
      end
    end
    assign v[k+1]  = v_q;
    assign cy[k+1] = cy_q;
    assign ps[PO +: (k+1)*SEG] = ps_q;
    if (k < STAGES - 1) begin : fwd
      logic [R-SEG-1:0] a_d, a_q, b_d, b_q;
      always_comb begin
        a_d = opa[OI+SEG +: R-SEG];
        b_d = opb[OI+SEG +: R-SEG];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
      assign opa[OI+R +: R-SEG] = a_q;
      assign opb[OI+R +: R-SEG] = b_q;
    end else begin : lst
      logic ovf_d, ovf_q, zero_d, zero_q;
      // carry into the MSB is recovered as a ^ b ^ sum at that bit
      always_comb begin
        ovf_d  = opa[OI+SEG-1] ^ opb[OI+SEG-1] ^ seg_s[SEG-1] ^ seg_s[SEG];
        zero_d = (ps_d == '0);
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
      assign ovf  = ovf_q;
      assign zero = zero_q;
    end
  end
endmodule

// File: doc/pipelined_rca.md
# pipelined_rca

Parametrised, pipelined ripple-carry adder/subtractor. It splits a WIDTH-bit operation into WIDTH/SEG segments and resolves one segment per pipeline stage, so the carry passes between stages through registers. It accepts one operation per cycle under a valid/ready handshake and produces the sum, carry/borrow, signed overflow and zero flags. It is the wide, high-throughput successor to the fixed-width combinational ripple adders in the datapath.

## Interface
Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per stage; STAGES = WIDTH/SEG (default 4).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept an operand bundle this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in for add; borrow-in for subtract.
- op_sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry-out for add; NOT-borrow for subtract.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Add: {c_out, sum} = a + b + c_in.
- Subtract: b is replaced by ~b and the carry-in by !c_in, so sum = a − b − c_in mod 2^WIDTH. c_out = 1 means no borrow.
- Stage k (k = 0..STAGES−1):
  - Adds bits [k·SEG+SEG−1 : k·SEG] using the carry registered by stage k−1. Stage 0 uses the transformed c_in.
  - Registers its partial sum.
  - Carries the still-unused upper operand bits forward (skew registers) so each stage sees its own segment.
  - Lower partial sums travel forward (deskew) so the final stage presents the full sum aligned.
- ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. It is computed in the last stage.
- zero is computed from the complete aligned sum in the last stage.
- Each stage holds a valid bit. There is no FSM; control is the per-stage valid chain plus a global advance enable.
- advance = !out_valid || out_ready. in_ready = advance.
- When advance = 0, every stage register, including the outputs, holds. When advance = 1, all stages shift together and empty stages carry valid = 0 (bubbles).
- Outputs (sum, c_out, ovf, zero) are driven from last-stage registers. They stay stable while out_valid && !out_ready.

## Timing
- Reset (rst_n = 0, asynchronous): all stage valids = 0, out_valid = 0, sum = 0, c_out = 0, ovf = 0, zero = 0. Operand registers clear to 0.
- in_ready is combinational from out_valid and out_ready, and is 1 immediately after reset.
- Latency: a bundle accepted at edge t produces out_valid = 1 after edge t+STAGES−1, provided no stall occurs. For the default, that is 4 edges including the accepting one.
- Throughput: 1 operation per cycle while out_ready = 1.
- Stall: each cycle with out_valid && !out_ready adds one cycle of latency to every in-flight operation. No operation is dropped, duplicated or reordered.
- Simultaneous output transfer and input transfer in the same cycle is legal and required at full rate.
- Bubbles are not collapsed: a valid-0 stage still occupies its slot during stalls.
- Reset asserted mid-operation discards all in-flight operations. After release, the first out_valid comes only from a bundle accepted after release.
- Wrap-around: sum is modulo 2^WIDTH, and the overflow bit is reported only via c_out and ovf.
- STAGES = 1 degenerates to a single registered adder with latency 1.

## Test plan
- Reset: hold rst_n = 0 with random inputs → all outputs 0, in_ready = 1. Release, no in_valid for 10 cycles → out_valid stays 0.
- Add carry/wrap (WIDTH = 16, SEG = 4): a = 0xFFFF, b = 0x0001, c_in = 0, op_sub = 0 → 4 cycles later sum = 0x0000, c_out = 1, ovf = 0, zero = 1. Then a = 0x7FFF, b = 0x0001 → sum = 0x8000, c_out = 0, ovf = 1, zero = 0.
- Subtract: a = 0x0005, b = 0x0007, c_in = 0 → sum = 0xFFFE, c_out = 0, ovf = 0. Then a = 0x8000, b = 0x0001, c_in = 0 → sum = 0x7FFF, c_out = 1, ovf = 1. Then a = 0x0010, b = 0x0004, c_in = 1 → sum = 0x000B, c_out = 1.
- Backpressure: stream 8 back-to-back adds (a = i, b = 0x0100·i) with out_ready low for cycles 5–7 → in_ready low exactly in those cycles, the held result is stable, and all 8 results arrive in order with correct values.
- Reset mid-flight: accept 3 operations, assert rst_n low for 1 cycle before any result → none of the 3 appear. A subsequent op (0x1234 + 0x1111) yields 0x2345 after 4 cycles.
- Random regression: 10k random a, b, c_in, op_sub with random out_ready at WIDTH = 32, SEG = 8 and at WIDTH = 16, SEG = 16 → every result matches the reference model, with no loss or reordering.
